// File: rtl/usb_bus_sched.sv
// usb_bus_sched: FT245-style asynchronous FIFO bus controller for the FT2232H.
// Bridges the chip's rxf/txe/rd/wr/data pins to a TX (fabric->host) and an
// RX (host->fabric) valid/ready byte stream, arbitrating round-robin.
module usb_bus_sched #(
    parameter int unsigned STROBE_CYCLES  = 2,
    parameter int unsigned RECOVER_CYCLES = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       rxf,
    input  logic       txe,
    output logic       rd,
    output logic       wr,
    inout  wire  [7:0] data_tristate,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] STROBE_LOAD  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TXSETUP  = 3'd1,
        ST_TXSTROBE = 3'd2,
        ST_TXHOLD   = 3'd3,
        ST_RXSTROBE = 3'd4,
        ST_RECOVER  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rxf_meta_q, rxf_s_q;
    logic               txe_meta_q, txe_s_q;
    logic               last_tx_q, last_tx_d;
    logic [DATA_W-1:0]  tx_byte_q, tx_byte_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               oe_q, oe_d;
    logic               busy_q, busy_d;

    logic               in_idle;
    logic               tx_elig, rx_elig;
    logic               grant_tx, grant_rx;
    logic               cnt_zero;
    logic               rx_capture;

    // Two-flop synchronizers for the asynchronous chip flags; reset to "not ready".
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rxf_meta_q <= 1'b1;
            rxf_s_q    <= 1'b1;
            txe_meta_q <= 1'b1;
            txe_s_q    <= 1'b1;
        end else begin
            rxf_meta_q <= rxf;
            rxf_s_q    <= rxf_meta_q;
            txe_meta_q <= txe;
            txe_s_q    <= txe_meta_q;
        end
    end

    // Eligibility and round-robin grant, only meaningful in IDLE.
    always_comb begin
        in_idle  = (state_q == ST_IDLE);
        tx_elig  = in_idle & tx_valid & ~txe_s_q;
        rx_elig  = in_idle & ~rxf_s_q & (~rx_valid_q | rx_ready);
        grant_tx = tx_elig & (~rx_elig | ~last_tx_q);
        grant_rx = rx_elig & (~tx_elig | last_tx_q);
        cnt_zero = (cnt_q == '0);
    end

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_tx) begin
                    state_d = ST_TXSETUP;
                end else if (grant_rx) begin
                    state_d = ST_RXSTROBE;
                end
            end
            ST_TXSETUP:  state_d = ST_TXSTROBE;
            ST_TXSTROBE: if (cnt_zero) state_d = ST_TXHOLD;
            ST_TXHOLD:   state_d = ST_RECOVER;
            ST_RXSTROBE: if (cnt_zero) state_d = ST_RECOVER;
            ST_RECOVER:  if (cnt_zero) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: pin strobes are decoded from the next state so the
    // registered pins line up with the state they belong to.
    always_comb begin
        rd_d     = 1'b1;
        wr_d     = 1'b1;
        oe_d     = 1'b0;
        busy_d   = 1'b1;
        tx_ready = 1'b0;
        case (state_d)
            ST_IDLE:     busy_d = 1'b0;
            ST_TXSETUP:  oe_d   = 1'b1;
            ST_TXSTROBE: begin
                oe_d = 1'b1;
                wr_d = 1'b0;
            end
            ST_TXHOLD:   oe_d   = 1'b1;
            ST_RXSTROBE: rd_d   = 1'b0;
            default:     ;
        endcase
        if (grant_tx) begin
            tx_ready = 1'b1;
        end
    end

    // Phase counter: load N-1 on state entry, count down, exit at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                ST_TXSTROBE,
                ST_RXSTROBE: cnt_d = STROBE_LOAD;
                ST_RECOVER:  cnt_d = RECOVER_LOAD;
                default:     cnt_d = '0;
            endcase
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Datapath next values: TX byte latch, RX capture, fairness pointer.
    always_comb begin
        tx_byte_d  = tx_byte_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        last_tx_d  = last_tx_q;
        rx_capture = (state_q == ST_RXSTROBE) & cnt_zero;
        if (grant_tx) begin
            tx_byte_d = tx_data;
            last_tx_d = 1'b1;
        end else if (grant_rx) begin
            last_tx_d = 1'b0;
        end
        if (rx_capture) begin
            rx_data_d  = data_tristate;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q & rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // Counter, datapath and pin registers; reset parks the pins idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            last_tx_q  <= 1'b1;
            tx_byte_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            last_tx_q  <= last_tx_d;
            tx_byte_q  <= tx_byte_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
        end
    end

    assign data_tristate = oe_q ? tx_byte_q : {DATA_W{1'bz}};
    assign rd            = rd_q;
    assign wr            = wr_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign busy          = busy_q;

    // The chip must never see both strobes asserted.
    a_strobe_excl: assert property (@(posedge clock) disable iff (!resetn) !(!rd_q && !wr_q));

    // The bus is only driven while no read strobe is active.
    a_bus_no_fight: assert property (@(posedge clock) disable iff (!resetn) !(oe_q && !rd_q));

endmodule

// File: tb/tb_usb_bus_sched.sv
`timescale 1ns/1ps
module tb_usb_bus_sched;

    localparam int unsigned S = 2;
    localparam int unsigned R = 3;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       rxf = 1'b1;
    logic       txe = 1'b1;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] chip_byte = 8'h00;
    logic       rd, wr, tx_ready, rx_valid, busy;
    logic [7:0] rx_data;
    wire  [7:0] bus;

    // Chip model: drives the data bus while the read strobe is low.
    assign bus = (rd == 1'b0) ? chip_byte : 8'bzzzzzzzz;

    usb_bus_sched #(.STROBE_CYCLES(S), .RECOVER_CYCLES(R)) dut (
        .clock(clock), .resetn(resetn), .rxf(rxf), .txe(txe),
        .rd(rd), .wr(wr), .data_tristate(bus),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Values to drive in the next cycle.
    logic       d_resetn = 1'b0, d_rxf = 1'b1, d_txe = 1'b1, d_tx_valid = 1'b0, d_rx_ready = 1'b0;
    logic [7:0] d_tx_data = 8'h00, d_chip = 8'h00;

    // Reference model: transfers as time windows relative to the grant cycle.
    int unsigned cyc, g_cyc, idle_at;
    int          kind;          // 0 none, 1 TX, 2 RX
    logic        m_last_tx, m_rx_valid;
    logic [7:0]  m_rx_data, m_tx_byte;
    logic        rxf_p1, rxf_p2, txe_p1, txe_p2;
    logic        have_prev, p_capture, p_rx_ready, p_rxf, p_txe;
    logic [7:0]  p_chip;
    logic        exp_rd, exp_wr, exp_oe, exp_busy, exp_tx_ready, exp_rx_valid;
    logic [7:0]  exp_rx_data, exp_byte;

    task automatic model_reset();
        cyc = 0; g_cyc = 0; idle_at = 0; kind = 0;
        m_last_tx = 1'b1; m_rx_valid = 1'b0; m_rx_data = 8'h00; m_tx_byte = 8'h00;
        rxf_p1 = 1'b1; rxf_p2 = 1'b1; txe_p1 = 1'b1; txe_p2 = 1'b1;
        have_prev = 1'b0; p_capture = 1'b0;
    endtask

    // Advance one cycle: apply inputs at the falling edge, then compute what
    // the DUT must show during this cycle. Comparisons are left to callers.
    task automatic tick();
        logic tx_el, rx_el;
        @(negedge clock);
        if (have_prev) begin
            if (p_capture) begin
                m_rx_valid = 1'b1;
                m_rx_data  = p_chip;
            end else if (m_rx_valid && p_rx_ready) begin
                m_rx_valid = 1'b0;
            end
            rxf_p2 = rxf_p1; rxf_p1 = p_rxf;
            txe_p2 = txe_p1; txe_p1 = p_txe;
            cyc++;
        end
        resetn = d_resetn; rxf = d_rxf; txe = d_txe; tx_valid = d_tx_valid;
        tx_data = d_tx_data; rx_ready = d_rx_ready; chip_byte = d_chip;
        #1;
        if (!d_resetn) begin
            model_reset();
            exp_rd = 1'b1; exp_wr = 1'b1; exp_oe = 1'b0; exp_busy = 1'b0;
            exp_tx_ready = 1'b0; exp_rx_valid = 1'b0; exp_rx_data = 8'h00; exp_byte = 8'h00;
        end else begin
            exp_busy     = (cyc < idle_at);
            exp_rd       = !(kind == 2 && cyc >= g_cyc + 1 && cyc <= g_cyc + S);
            exp_wr       = !(kind == 1 && cyc >= g_cyc + 2 && cyc <= g_cyc + S + 1);
            exp_oe       = (kind == 1 && cyc >= g_cyc + 1 && cyc <= g_cyc + S + 2);
            exp_byte     = m_tx_byte;
            exp_rx_valid = m_rx_valid;
            exp_rx_data  = m_rx_data;
            exp_tx_ready = 1'b0;
            if (!exp_busy) begin
                tx_el = d_tx_valid && !txe_p2;
                rx_el = !rxf_p2 && (!m_rx_valid || d_rx_ready);
                if (tx_el && (!rx_el || !m_last_tx)) begin
                    exp_tx_ready = 1'b1;
                    kind = 1; g_cyc = cyc; idle_at = cyc + S + R + 3;
                    m_tx_byte = d_tx_data; m_last_tx = 1'b1;
                end else if (rx_el) begin
                    kind = 2; g_cyc = cyc; idle_at = cyc + S + R + 1;
                    m_last_tx = 1'b0;
                end
            end
            p_capture  = (kind == 2 && cyc == g_cyc + S);
            p_chip     = d_chip;
            p_rx_ready = d_rx_ready;
            p_rxf      = d_rxf;
            p_txe      = d_txe;
            have_prev  = 1'b1;
        end
    endtask

    task automatic do_reset();
        d_resetn = 1'b0;
        repeat (2) tick();
        d_resetn = 1'b1;
    endtask

    task automatic test_reset();
        int first_rd;
        d_rxf = 1'b0; d_txe = 1'b0; d_tx_valid = 1'b1; d_rx_ready = 1'b1; d_chip = 8'h11;
        d_resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (rd !== 1'b1) begin n_err++; $display("FAIL reset_rd: got %b expected 1", rd); end
            n_cmp++; if (wr !== 1'b1) begin n_err++; $display("FAIL reset_wr: got %b expected 1", wr); end
            n_cmp++; if (dut.oe_q !== 1'b0) begin n_err++; $display("FAIL reset_bus_z: oe got %b expected 0", dut.oe_q); end
            n_cmp++; if (rx_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_flags: rx_valid/busy got %b%b expected 00", rx_valid, busy); end
        end
        d_resetn = 1'b1;
        first_rd = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rd == 1'b0 && first_rd < 0) first_rd = int'(cyc);
            n_cmp++; if (wr !== 1'b1) begin n_err++; $display("FAIL reset_tie_wr @%0d: got %b expected 1", cyc, wr); end
        end
        // Flags reach eligibility after two edges: grant in cycle 2, rd low in cycle 3; RX wins first tie.
        n_cmp++; if (first_rd !== 3) begin n_err++; $display("FAIL reset_first_grant: rd low at %0d expected 3", first_rd); end
    endtask

    task automatic test_single_tx();
        int g1, g2, wr_low;
        d_rxf = 1'b1; d_txe = 1'b0; d_tx_valid = 1'b1; d_tx_data = 8'hA5; d_rx_ready = 1'b1;
        do_reset();
        g1 = -1; g2 = -1; wr_low = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++; if (tx_ready !== exp_tx_ready) begin n_err++; $display("FAIL tx_ready @%0d: got %b expected %b", cyc, tx_ready, exp_tx_ready); end
            n_cmp++; if (wr !== exp_wr) begin n_err++; $display("FAIL tx_wr @%0d: got %b expected %b", cyc, wr, exp_wr); end
            n_cmp++; if (dut.oe_q !== exp_oe) begin n_err++; $display("FAIL tx_oe @%0d: got %b expected %b", cyc, dut.oe_q, exp_oe); end
            if (tx_ready == 1'b1) begin
                if (g1 < 0) begin g1 = int'(cyc); d_tx_data = 8'h5A; end
                else if (g2 < 0) g2 = int'(cyc);
            end
            if (g1 >= 0 && g2 < 0 && wr == 1'b0) wr_low++;
            if (g1 >= 0 && g2 < 0 && exp_oe) begin
                n_cmp++; if (bus !== 8'hA5) begin n_err++; $display("FAIL tx_bus @%0d: got %h expected a5", cyc, bus); end
            end
        end
        n_cmp++; if (g1 !== 2) begin n_err++; $display("FAIL tx_first_grant: got %0d expected 2", g1); end
        n_cmp++; if (wr_low !== 2) begin n_err++; $display("FAIL tx_wr_width: got %0d expected 2", wr_low); end
        n_cmp++; if (g2 - g1 !== 8) begin n_err++; $display("FAIL tx_period: got %0d expected 8", g2 - g1); end
    endtask

    task automatic test_single_rx();
        int first_rd, rd_low, first_v;
        d_rxf = 1'b0; d_txe = 1'b1; d_tx_valid = 1'b0; d_rx_ready = 1'b0; d_chip = 8'h3C;
        do_reset();
        first_rd = -1; rd_low = 0; first_v = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL rx_rd @%0d: got %b expected %b", cyc, rd, exp_rd); end
            n_cmp++; if (rx_valid !== exp_rx_valid) begin n_err++; $display("FAIL rx_valid @%0d: got %b expected %b", cyc, rx_valid, exp_rx_valid); end
            if (rd == 1'b0) begin rd_low++; if (first_rd < 0) first_rd = int'(cyc); end
            if (rx_valid == 1'b1 && first_v < 0) begin
                first_v = int'(cyc);
                n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL rx_data: got %h expected 3c", rx_data); end
            end
        end
        n_cmp++; if (rd_low !== 2) begin n_err++; $display("FAIL rx_rd_width: got %0d expected 2", rd_low); end
        // Grant in cycle 2: rd low from 3, rx_valid from grant+3 = 5.
        n_cmp++; if (first_rd !== 3 || first_v !== 5) begin n_err++; $display("FAIL rx_timing: rd at %0d valid at %0d expected 3 and 5", first_rd, first_v); end
    endtask

    // Continues from test_single_rx with an unconsumed byte held.
    task automatic test_rx_backpressure();
        int rd_low, wr_low, first_idle, rd_at;
        d_txe = 1'b0; d_tx_valid = 1'b1; d_tx_data = 8'h77;
        rd_low = 0; wr_low = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (rd == 1'b0) rd_low++;
            if (wr == 1'b0) wr_low++;
            n_cmp++; if (wr !== exp_wr) begin n_err++; $display("FAIL bp_wr @%0d: got %b expected %b", cyc, wr, exp_wr); end
        end
        n_cmp++; if (rd_low !== 0) begin n_err++; $display("FAIL bp_no_read: got %0d rd cycles expected 0", rd_low); end
        n_cmp++; if ((wr_low > 0) !== 1'b1) begin n_err++; $display("FAIL bp_tx_continues: got %0d wr cycles expected >0", wr_low); end
        d_rx_ready = 1'b1;
        first_idle = -1; rd_at = -1;
        for (int i = 0; i < 30 && rd_at < 0; i++) begin
            tick();
            if (busy == 1'b0 && first_idle < 0) first_idle = int'(cyc);
            if (rd == 1'b0) rd_at = int'(cyc);
            n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL bp_rd @%0d: got %b expected %b", cyc, rd, exp_rd); end
        end
        n_cmp++; if (rd_at < 0 || rd_at !== first_idle + 1) begin n_err++; $display("FAIL bp_resume: rd low at %0d expected %0d", rd_at, first_idle + 1); end
    endtask

    task automatic test_round_robin();
        int  n_grant;
        logic prev_rd, want_tx;
        d_rxf = 1'b0; d_txe = 1'b0; d_tx_valid = 1'b1; d_rx_ready = 1'b1;
        do_reset();
        n_grant = 0; prev_rd = 1'b1;
        for (int i = 0; i < 64; i++) begin
            d_chip = 8'($urandom); d_tx_data = 8'($urandom);
            tick();
            want_tx = (n_grant % 2) == 1;
            if (rd == 1'b0 && prev_rd == 1'b1) begin
                n_cmp++; if (want_tx !== 1'b0) begin n_err++; $display("FAIL rr_order grant %0d: got RX expected TX", n_grant); end
                n_grant++;
            end
            if (tx_ready == 1'b1) begin
                n_cmp++; if (want_tx !== 1'b1) begin n_err++; $display("FAIL rr_order grant %0d: got TX expected RX", n_grant); end
                n_grant++;
            end
            n_cmp++; if ((rd == 1'b0 && wr == 1'b0) !== 1'b0) begin n_err++; $display("FAIL rr_strobe_overlap @%0d: rd=%b wr=%b", cyc, rd, wr); end
            prev_rd = rd;
        end
        n_cmp++; if ((n_grant >= 8) !== 1'b1) begin n_err++; $display("FAIL rr_grant_count: got %0d expected >=8", n_grant); end
    endtask

    task automatic test_reset_mid_strobe();
        int waited;
        d_rxf = 1'b1; d_txe = 1'b0; d_tx_valid = 1'b1; d_tx_data = 8'hC3; d_rx_ready = 1'b1;
        do_reset();
        waited = 0;
        while (wr !== 1'b0 && waited < 20) begin tick(); waited++; end
        n_cmp++; if (wr !== 1'b0) begin n_err++; $display("FAIL mid_reach_strobe: wr got %b expected 0", wr); end
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (wr !== 1'b1 || rd !== 1'b1) begin n_err++; $display("FAIL mid_strobes: rd/wr got %b%b expected 11", rd, wr); end
        n_cmp++; if (dut.oe_q !== 1'b0) begin n_err++; $display("FAIL mid_bus_z: oe got %b expected 0", dut.oe_q); end
        d_resetn = 1'b0; d_txe = 1'b1;
        repeat (2) tick();
        d_resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (busy !== 1'b0 || busy !== exp_busy) begin n_err++; $display("FAIL mid_idle @%0d: busy got %b expected 0", cyc, busy); end
            n_cmp++; if (rx_valid !== 1'b0 || wr !== 1'b1) begin n_err++; $display("FAIL mid_after: rx_valid/wr got %b%b expected 01", rx_valid, wr); end
        end
    endtask

    task automatic test_random();
        d_rxf = 1'b1; d_txe = 1'b1; d_tx_valid = 1'b0; d_rx_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) d_rxf = ~d_rxf;
            if ($urandom_range(0, 7) == 0) d_txe = ~d_txe;
            d_tx_valid = ($urandom_range(0, 3) != 0);
            d_rx_ready = ($urandom_range(0, 2) != 0);
            d_tx_data  = 8'($urandom);
            d_chip     = 8'($urandom);
            tick();
            n_cmp++; if (rd !== exp_rd) begin n_err++; $display("FAIL rnd_rd @%0d: got %b expected %b", cyc, rd, exp_rd); end
            n_cmp++; if (wr !== exp_wr) begin n_err++; $display("FAIL rnd_wr @%0d: got %b expected %b", cyc, wr, exp_wr); end
            n_cmp++; if (dut.oe_q !== exp_oe) begin n_err++; $display("FAIL rnd_oe @%0d: got %b expected %b", cyc, dut.oe_q, exp_oe); end
            n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy @%0d: got %b expected %b", cyc, busy, exp_busy); end
            n_cmp++; if (tx_ready !== exp_tx_ready) begin n_err++; $display("FAIL rnd_tx_ready @%0d: got %b expected %b", cyc, tx_ready, exp_tx_ready); end
            n_cmp++; if (rx_valid !== exp_rx_valid) begin n_err++; $display("FAIL rnd_rx_valid @%0d: got %b expected %b", cyc, rx_valid, exp_rx_valid); end
            n_cmp++; if (rx_data !== exp_rx_data) begin n_err++; $display("FAIL rnd_rx_data @%0d: got %h expected %h", cyc, rx_data, exp_rx_data); end
            if (exp_oe) begin
                n_cmp++; if (bus !== exp_byte) begin n_err++; $display("FAIL rnd_bus @%0d: got %h expected %h", cyc, bus, exp_byte); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_tx();
        test_single_rx();
        test_rx_backpressure();
        test_round_robin();
        test_reset_mid_strobe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
